// File: rtl/running_max_stage_pkg.sv
// Shared types for the running-max producer stage of the exp-multiply
// datapath: score and V-row types, the operand-beat record and FSM states.
package running_max_stage_pkg;

    localparam int DOT_PRODUCT_SIZE  = 32;
    localparam int MAX_EMBEDDING_DIM = 64;

    typedef logic signed [DOT_PRODUCT_SIZE-1:0] int_t;

    // One V row: lanes 0..MAX_EMBEDDING_DIM inclusive.
    typedef int_t [0:MAX_EMBEDDING_DIM] star_vector_t;

    // Operand beat handed to exp-multiply: it computes exp(a-b) and either
    // scales its accumulator (rescale=1) or accumulates exp(a-b)*v.
    typedef struct packed {
        int_t         a;
        int_t         b;
        star_vector_t v;
        logic         rescale;
        logic         last;
    } op_beat_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RSC   = 2'd1,
        S_VAL   = 2'd2
    } state_t;

    // Beat that rescales the accumulator by exp(m_old - m_new).
    function automatic op_beat_t rescale_beat(int_t m_old, int_t m_new);
        op_beat_t beat;
        beat         = '0;
        beat.a       = m_old;
        beat.b       = m_new;
        beat.rescale = 1'b1;
        return beat;
    endfunction

    // Beat that accumulates exp(s - m_new) * v.
    function automatic op_beat_t value_beat(int_t s, int_t m_new,
                                            star_vector_t v, logic last);
        op_beat_t beat;
        beat         = '0;
        beat.a       = s;
        beat.b       = m_new;
        beat.v       = v;
        beat.rescale = 1'b0;
        beat.last    = last;
        return beat;
    endfunction

endpackage

// File: rtl/running_max_stage_if.sv
// Handshake bundle around the running-max stage: the score/V stream coming
// from the QK stage and the operand-beat stream going to exp-multiply.
// slave is the stage's view, master is the view of whatever drives it.
interface running_max_stage_if;
    import running_max_stage_pkg::*;

    logic         vld_in;
    logic         rdy_out;
    int_t         score_in;
    star_vector_t v_in;
    logic         last_in;

    logic         vld_out;
    logic         rdy_in;
    int_t         a_out;
    int_t         b_out;
    star_vector_t v_out;
    logic         rescale_out;
    logic         last_out;

    modport slave (
        input  vld_in, score_in, v_in, last_in, rdy_in,
        output rdy_out, vld_out, a_out, b_out, v_out, rescale_out, last_out
    );

    modport master (
        output vld_in, score_in, v_in, last_in, rdy_in,
        input  rdy_out, vld_out, a_out, b_out, v_out, rescale_out, last_out
    );

endinterface

// File: rtl/running_max_stage_signed_max.sv
// Combinational signed max of two scores plus a strict a > b flag.
// Shared by the max/reduce stages; ties resolve to b with a_gt_b=0.
module signed_max
    import running_max_stage_pkg::*;
(
    input  int_t a,
    input  int_t b,
    output int_t max_out,
    output logic a_gt_b
);

    // Both operands are int_t (signed), so the compare is two's complement.
    always_comb begin
        a_gt_b  = (a > b);
        max_out = a_gt_b ? a : b;
    end

endmodule

// File: rtl/running_max_stage.sv
// Running-max producer for online softmax. Accepts one (score, V row) per
// key, tracks the running max m across the keys of a query, and emits a
// RESCALE beat exp(m_old-m_new) whenever m grows, followed by the VALUE
// beat exp(s-m_new)*v of that key.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_EMPTY | no beat pending; ready for a key
//  S_RSC   | RESCALE beat presented; VALUE beat of same key waits in key_*
//  S_VAL   | VALUE beat presented; can reload from upstream when accepted
module running_max_stage
    import running_max_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    running_max_stage_if.slave     bus
);

    state_t       state_q;
    state_t       state_d;

    op_beat_t     beat_q;

    int_t         m_reg;
    logic         first_q;

    // VALUE beat of a key that is waiting behind its RESCALE beat.
    int_t         key_s;
    int_t         key_m_new;
    star_vector_t key_v;
    logic         key_last;

    int_t         max_s;
    logic         s_gt_m;
    int_t         m_new;
    logic         need_rsc;
    logic         rdy_out;
    logic         in_xfer;
    logic         out_xfer;

    signed_max u_max (
        .a       (bus.score_in),
        .b       (m_reg),
        .max_out (max_s),
        .a_gt_b  (s_gt_m)
    );

    // Ready depends on rdy_in combinationally so a VALUE beat leaving and
    // the next key arriving can share a cycle (1 key/cycle throughput).
    always_comb begin
        rdy_out  = (state_q == S_EMPTY) || (state_q == S_VAL && bus.rdy_in);
        in_xfer  = bus.vld_in && rdy_out;
        out_xfer = (state_q != S_EMPTY) && bus.rdy_in;
        // The first key of a query never rescales, whatever the old max was.
        m_new    = first_q ? bus.score_in : max_s;
        need_rsc = !first_q && s_gt_m;
    end

    // Next-state decode of the beat sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_d = need_rsc ? S_RSC : S_VAL;
                end
            end
            S_RSC: begin
                if (out_xfer) begin
                    state_d = S_VAL;
                end
            end
            S_VAL: begin
                if (in_xfer) begin
                    state_d = need_rsc ? S_RSC : S_VAL;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Running max, first-key flag, pending key and the presented beat. The
    // beat register only changes on a load, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            m_reg     <= '0;
            first_q   <= 1'b1;
            key_s     <= '0;
            key_m_new <= '0;
            key_v     <= '0;
            key_last  <= 1'b0;
        end else if (in_xfer) begin
            m_reg     <= m_new;
            first_q   <= bus.last_in;
            key_s     <= bus.score_in;
            key_m_new <= m_new;
            key_v     <= bus.v_in;
            key_last  <= bus.last_in;
            if (need_rsc) begin
                beat_q <= rescale_beat(m_reg, m_new);
            end else begin
                beat_q <= value_beat(bus.score_in, m_new, bus.v_in, bus.last_in);
            end
        end else if (state_q == S_RSC && out_xfer) begin
            beat_q <= value_beat(key_s, key_m_new, key_v, key_last);
        end
    end

    // Output drive from the held beat.
    always_comb begin
        bus.rdy_out     = rdy_out;
        bus.vld_out     = (state_q != S_EMPTY);
        bus.a_out       = beat_q.a;
        bus.b_out       = beat_q.b;
        bus.v_out       = beat_q.v;
        bus.rescale_out = beat_q.rescale;
        bus.last_out    = beat_q.last;
    end

endmodule

// File: tb/tb_running_max_stage.sv
// Directed bench for running_max_stage: score sequences with hand-computed
// operand beats, backpressure on a RESCALE beat, query boundaries, and a
// reset that lands mid-beat.
module tb_running_max_stage;
    import running_max_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   low_rdy = 0;

    running_max_stage_if bus ();

    running_max_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int_t         obs_a[$];
    int_t         obs_b[$];
    logic         obs_r[$];
    logic         obs_l[$];
    star_vector_t obs_v[$];
    int           obs_c[$];

    // Record every accepted beat and every cycle with rdy_out low.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vld_out && bus.rdy_in) begin
                obs_a.push_back(bus.a_out);
                obs_b.push_back(bus.b_out);
                obs_r.push_back(bus.rescale_out);
                obs_l.push_back(bus.last_out);
                obs_v.push_back(bus.v_out);
                obs_c.push_back(cyc);
            end
            if (!bus.rdy_out) low_rdy++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1);
    end

    function automatic star_vector_t v_for(int tag);
        star_vector_t r;
        r = '0;
        if (tag >= 0) begin
            for (int i = 0; i <= MAX_EMBEDDING_DIM; i++) r[i] = int_t'(tag * 1000 + i);
        end
        return r;
    endfunction

    task automatic clear_obs();
        obs_a.delete(); obs_b.delete(); obs_r.delete();
        obs_l.delete(); obs_v.delete(); obs_c.delete();
        low_rdy = 0;
    endtask

    task automatic send_keys(input int n, input int sc[6], input bit ls[6], input int tag0);
        bit acc;
        int g;
        for (int k = 0; k < n; k++) begin
            bus.score_in = int_t'(sc[k]);
            bus.v_in     = v_for(tag0 + k);
            bus.last_in  = ls[k];
            bus.vld_in   = 1'b1;
            acc = 1'b0;
            g   = 0;
            while (!acc && g < 20) begin
                @(negedge clk);
                acc = bus.rdy_out;
                @(posedge clk); #1;
                g++;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL send key%0d: rdy_out stayed 0 for 20 cycles, want 1", k);
            end
        end
        bus.vld_in  = 1'b0;
        bus.last_in = 1'b0;
    endtask

    task automatic drain(input int n);
        int g;
        g = 0;
        while (obs_a.size() < n && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.vld_in = 1'b0; bus.score_in = '0; bus.v_in = '0;
        bus.last_in = 1'b0; bus.rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL reset vld_out: got %b want 0", bus.vld_out); end
        n_vec++; if (bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL reset rdy_out: got %b want 1", bus.rdy_out); end
        n_vec++; if (bus.a_out !== 0 || bus.b_out !== 0) begin n_err++; $display("FAIL reset a/b: got %0d/%0d want 0/0", bus.a_out, bus.b_out); end
        n_vec++; if (bus.v_out !== '0) begin n_err++; $display("FAIL reset v_out: got nonzero want 0"); end
        n_vec++; if (bus.rescale_out !== 1'b0 || bus.last_out !== 1'b0) begin n_err++; $display("FAIL reset flags: got r=%b l=%b want 0/0", bus.rescale_out, bus.last_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_descending();
        int ea[6] = '{5, 3, 1, 0, 0, 0};
        int eb[6] = '{5, 5, 5, 0, 0, 0};
        bit er[6] = '{0, 0, 0, 0, 0, 0};
        bit el[6] = '{0, 0, 1, 0, 0, 0};
        int et[6] = '{10, 11, 12, 0, 0, 0};
        clear_obs();
        send_keys(3, '{5, 3, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}, 10);
        drain(3);
        n_vec++; if (obs_a.size() != 3) begin n_err++; $display("FAIL desc count: got %0d want 3", obs_a.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_r[i] !== er[i] || obs_l[i] !== el[i] || obs_v[i] !== v_for(et[i])) begin
                n_err++;
                $display("FAIL desc beat%0d: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=%0d b=%0d r=%b l=%b",
                         i, obs_a[i], obs_b[i], obs_r[i], obs_l[i], obs_v[i] === v_for(et[i]), ea[i], eb[i], er[i], el[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_c[i+1] - obs_c[i] != 1) begin n_err++; $display("FAIL desc spacing%0d: got %0d cycles want 1", i, obs_c[i+1] - obs_c[i]); end
        end
        n_vec++; if (low_rdy != 0) begin n_err++; $display("FAIL desc rdy_out low cycles: got %0d want 0", low_rdy); end
    endtask

    task automatic test_rising();
        int ea[6] = '{1, 1, 4, 4, 4, 9};
        int eb[6] = '{1, 4, 4, 4, 9, 9};
        bit er[6] = '{0, 1, 0, 0, 1, 0};
        bit el[6] = '{0, 0, 0, 0, 0, 1};
        int et[6] = '{20, -1, 21, 22, -1, 23};
        clear_obs();
        send_keys(4, '{1, 4, 4, 9, 0, 0}, '{0, 0, 0, 1, 0, 0}, 20);
        drain(6);
        n_vec++; if (obs_a.size() != 6) begin n_err++; $display("FAIL rise count: got %0d want 6", obs_a.size()); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_r[i] !== er[i] || obs_l[i] !== el[i] || obs_v[i] !== v_for(et[i])) begin
                n_err++;
                $display("FAIL rise beat%0d: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=%0d b=%0d r=%b l=%b",
                         i, obs_a[i], obs_b[i], obs_r[i], obs_l[i], obs_v[i] === v_for(et[i]), ea[i], eb[i], er[i], el[i]);
            end
        end
        n_vec++; if (low_rdy != 2) begin n_err++; $display("FAIL rise rdy_out low cycles: got %0d want 2", low_rdy); end
    endtask

    task automatic test_negative();
        int ea[6] = '{-7, -7, -2, 0, 0, 0};
        int eb[6] = '{-7, -2, -2, 0, 0, 0};
        bit er[6] = '{0, 1, 0, 0, 0, 0};
        bit el[6] = '{0, 0, 1, 0, 0, 0};
        int et[6] = '{30, -1, 31, 0, 0, 0};
        clear_obs();
        send_keys(2, '{-7, -2, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0}, 30);
        drain(3);
        n_vec++; if (obs_a.size() != 3) begin n_err++; $display("FAIL neg count: got %0d want 3", obs_a.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_r[i] !== er[i] || obs_l[i] !== el[i] || obs_v[i] !== v_for(et[i])) begin
                n_err++;
                $display("FAIL neg beat%0d: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=%0d b=%0d r=%b l=%b",
                         i, obs_a[i], obs_b[i], obs_r[i], obs_l[i], obs_v[i] === v_for(et[i]), ea[i], eb[i], er[i], el[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ea[6] = '{2, 2, 6, 7, 0, 0};
        int eb[6] = '{2, 6, 6, 7, 0, 0};
        bit er[6] = '{0, 1, 0, 0, 0, 0};
        bit el[6] = '{0, 0, 1, 1, 0, 0};
        int et[6] = '{40, -1, 41, 42, 0, 0};
        clear_obs();
        bus.rdy_in = 1'b1;
        bus.vld_in = 1'b1; bus.score_in = 2; bus.v_in = v_for(40); bus.last_in = 1'b0;
        @(posedge clk); #1;
        bus.score_in = 6; bus.v_in = v_for(41); bus.last_in = 1'b1;
        @(posedge clk); #1;
        bus.score_in = 7; bus.v_in = v_for(42); bus.last_in = 1'b1;
        bus.rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.vld_out !== 1'b1 || bus.a_out !== 2 || bus.b_out !== 6 || bus.rescale_out !== 1'b1 ||
                bus.last_out !== 1'b0 || bus.v_out !== '0 || bus.rdy_out !== 1'b0) begin
                n_err++;
                $display("FAIL bp hold%0d: got vld=%b a=%0d b=%0d r=%b l=%b vz=%b rdy=%b want 1 2 6 1 0 1 0",
                         k, bus.vld_out, bus.a_out, bus.b_out, bus.rescale_out, bus.last_out, bus.v_out === '0, bus.rdy_out);
            end
            @(posedge clk); #1;
        end
        bus.rdy_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.vld_in = 1'b0; bus.last_in = 1'b0;
        drain(4);
        n_vec++; if (obs_a.size() != 4) begin n_err++; $display("FAIL bp count: got %0d want 4", obs_a.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_r[i] !== er[i] || obs_l[i] !== el[i] || obs_v[i] !== v_for(et[i])) begin
                n_err++;
                $display("FAIL bp beat%0d: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=%0d b=%0d r=%b l=%b",
                         i, obs_a[i], obs_b[i], obs_r[i], obs_l[i], obs_v[i] === v_for(et[i]), ea[i], eb[i], er[i], el[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ea[6] = '{8, 10, 2, 0, 0, 0};
        int eb[6] = '{8, 10, 10, 0, 0, 0};
        bit er[6] = '{0, 0, 0, 0, 0, 0};
        bit el[6] = '{1, 0, 1, 0, 0, 0};
        int et[6] = '{50, 51, 52, 0, 0, 0};
        clear_obs();
        send_keys(3, '{8, 10, 2, 0, 0, 0}, '{1, 0, 1, 0, 0, 0}, 50);
        drain(3);
        n_vec++; if (obs_a.size() != 3) begin n_err++; $display("FAIL b2b count: got %0d want 3", obs_a.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_r[i] !== er[i] || obs_l[i] !== el[i] || obs_v[i] !== v_for(et[i])) begin
                n_err++;
                $display("FAIL b2b beat%0d: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=%0d b=%0d r=%b l=%b",
                         i, obs_a[i], obs_b[i], obs_r[i], obs_l[i], obs_v[i] === v_for(et[i]), ea[i], eb[i], er[i], el[i]);
            end
        end
    endtask

    task automatic test_reset_mid_beat();
        bus.rdy_in = 1'b1;
        bus.vld_in = 1'b1; bus.score_in = 1; bus.v_in = v_for(60); bus.last_in = 1'b0;
        @(posedge clk); #1;
        bus.score_in = 9; bus.v_in = v_for(61);
        @(posedge clk); #1;
        n_vec++; if (bus.rescale_out !== 1'b1 || bus.vld_out !== 1'b1) begin n_err++; $display("FAIL rst_mid setup: got vld=%b r=%b want 1/1", bus.vld_out, bus.rescale_out); end
        rst = 1'b1;
        bus.score_in = 11; bus.v_in = v_for(62);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.vld_in = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.vld_out !== 1'b0 || bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL rst_mid hs: got vld=%b rdy=%b want 0/1", bus.vld_out, bus.rdy_out); end
        n_vec++; if (dut.first_q !== 1'b1) begin n_err++; $display("FAIL rst_mid first_q: got %b want 1", dut.first_q); end
        n_vec++; if (bus.rescale_out !== 1'b0 || bus.a_out !== 0 || bus.b_out !== 0) begin n_err++; $display("FAIL rst_mid beat: got r=%b a=%0d b=%0d want 0 0 0", bus.rescale_out, bus.a_out, bus.b_out); end
        @(posedge clk); #1;
        clear_obs();
        send_keys(1, '{3, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 63);
        drain(1);
        n_vec++; if (obs_a.size() != 1) begin n_err++; $display("FAIL rst_mid count: got %0d want 1", obs_a.size()); end
        n_vec++;
        if (obs_a[0] !== 3 || obs_b[0] !== 3 || obs_r[0] !== 1'b0 || obs_l[0] !== 1'b1 || obs_v[0] !== v_for(63)) begin
            n_err++;
            $display("FAIL rst_mid beat0: got a=%0d b=%0d r=%b l=%b v_ok=%b want a=3 b=3 r=0 l=1",
                     obs_a[0], obs_b[0], obs_r[0], obs_l[0], obs_v[0] === v_for(63));
        end
    endtask

    initial begin
        test_reset();
        test_descending();
        test_rising();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_beat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
